// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg                                                           |
// | Shared 2-bit saturating counter encoding and update function.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hazard_pkg;

   typedef logic [1:0] cnt_t;

   localparam cnt_t CNT_SNT = 2'b00;
   localparam cnt_t CNT_WNT = 2'b01;
   localparam cnt_t CNT_WT  = 2'b10;
   localparam cnt_t CNT_ST  = 2'b11;

   function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
      cnt_t nxt;
      if (taken) begin
         nxt = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
      end else begin
         nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bht_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bht_table                                                            |
// | Bimodal counter array: async read, sync train, sync reset to WNT.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bht_table
   import hazard_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] i_rd_idx,
   output cnt_t             o_rd_cnt,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_taken
);

   cnt_t r_cnt [DEPTH];

   // Read returns the stored value; a same-cycle write is seen next cycle.
   assign o_rd_cnt = r_cnt[i_rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_cnt[i] <= CNT_WNT;
         end
      end else if (i_wr_en) begin
         r_cnt[i_wr_idx] <= cnt_next(r_cnt[i_wr_idx], i_wr_taken);
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_hazard_unit                                                   |
// | Branch prediction plus mispredict flush control for the MIPS core.   |
// | Optional macro: BRANCH_STATS_EN adds branch/mispredict counters.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_hazard_unit
   import hazard_pkg::*;
#(
   parameter int PC_WIDTH     = 32,
   parameter int BHT_DEPTH    = 16,
   parameter int NUM_FLUSH    = 3,
   parameter int PREDICT_MODE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid,
   input  logic [PC_WIDTH-1:0]  if_pc,
   output logic                 pred_taken,
   input  logic                 res_valid,
   input  logic [PC_WIDTH-1:0]  res_pc,
   input  logic                 res_taken,
   input  logic                 res_pred_taken,
   output logic                 mispredict,
   output logic                 redirect_taken,
`ifdef BRANCH_STATS_EN
   output logic [31:0]          stat_branches,
   output logic [31:0]          stat_mispredicts,
`endif
   output logic [NUM_FLUSH-1:0] flush
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [IDX_W-1:0] w_if_idx;
   logic [IDX_W-1:0] w_res_idx;
   cnt_t             w_pred_cnt;
   logic             w_mispredict;
   logic             w_unused;

   // Word-aligned PCs: drop the byte offset, ignore bits above the index.
   assign w_if_idx  = if_pc[IDX_W+1:2];
   assign w_res_idx = res_pc[IDX_W+1:2];

   generate
      if (PREDICT_MODE == 1) begin : g_bimodal
         bht_table #(
            .DEPTH (BHT_DEPTH),
            .IDX_W (IDX_W)
         ) u_bht (
            .clk        (clk),
            .reset      (reset),
            .i_rd_idx   (w_if_idx),
            .o_rd_cnt   (w_pred_cnt),
            .i_wr_en    (res_valid),
            .i_wr_idx   (w_res_idx),
            .i_wr_taken (res_taken)
         );
      end else begin : g_static
         assign w_pred_cnt = CNT_SNT;
      end
   endgenerate

   assign pred_taken     = if_valid & w_pred_cnt[1];
   assign w_mispredict   = res_valid & (res_taken != res_pred_taken);
   assign mispredict     = w_mispredict;
   assign redirect_taken = res_taken & w_mispredict;
   assign flush          = {NUM_FLUSH{w_mispredict}};

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_branches    <= 32'd0;
         r_stat_mispredicts <= 32'd0;
      end else begin
         if (res_valid && (r_stat_branches != 32'hFFFF_FFFF)) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`endif

   // Bits that are intentionally not consumed in some configurations.
   assign w_unused = ^{if_pc, res_pc, w_pred_cnt[0], clk, reset};

endmodule
`default_nettype wire

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

Parametrised control-hazard unit for the pipelined MIPS core, combining prediction and flush control. At fetch, it supplies a taken/not-taken prediction, either static not-taken or from a bimodal table of 2-bit saturating counters. At branch resolution, it compares the actual outcome with the prediction carried down the pipe. On a mismatch it flushes a configurable number of pipeline registers and trains the table.

## Interface
Parameters:
- PC_WIDTH, 32, width of program-counter inputs
- BHT_DEPTH, 16, counter-table entries; power of two, 2..1024
- NUM_FLUSH, 3, pipeline registers cleared on mispredict; bit 0 = IF/ID, bit 1 = ID/EX, bit 2 = EX/MEM, ...
- PREDICT_MODE, 1, 0 = static not-taken (no table), 1 = bimodal

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch stage holds a valid instruction
- if_pc  in  PC_WIDTH  fetch PC
- pred_taken  out  1  prediction for if_pc
- res_valid  in  1  a conditional branch resolves this cycle
- res_pc  in  PC_WIDTH  PC of the resolving branch
- res_taken  in  1  actual outcome
- res_pred_taken  in  1  prediction made for that branch at fetch
- mispredict  out  1  resolution disagrees with prediction
- redirect_taken  out  1  on mispredict: 1 = redirect to target, 0 = redirect to PC+4
- flush  out  NUM_FLUSH  per-register flush strobes

## Operation
- Index: idx = pc[IDX_W+1:2], with IDX_W = log2(BHT_DEPTH). Word-aligned PCs; upper bits are ignored (aliasing is allowed).
- pred_taken:
  - Combinational: if_valid & counter[idx(if_pc)][1].
  - When if_valid = 0, pred_taken = 0.
  - With PREDICT_MODE = 0, pred_taken is constant 0 and the table is not built.
- mispredict: combinational, res_valid & (res_taken != res_pred_taken).
- flush: all NUM_FLUSH bits equal mispredict; all bits are 0 otherwise. Mode 0 reproduces plain predict-not-taken flushing.
- redirect_taken: equals res_taken & mispredict; 0 otherwise.
- Training (mode 1): on every clk edge with res_valid = 1, counter[idx(res_pc)] saturates up if res_taken = 1, down otherwise. Training happens whether or not the branch mispredicted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. 11 + taken stays 11; 00 + not-taken stays 00.
- Same-index read/write in one cycle: pred_taken returns the pre-update value (no bypass).
- Outcome inputs are trusted. A res_valid arriving in the cycle after a mispredict is processed normally; the pipeline guarantees it belongs to the correct path.

## Timing
- Prediction: 0-cycle latency, same cycle as if_pc.
- mispredict, flush and redirect_taken: 0-cycle latency from res_*. The flush strobe lasts exactly the cycles in which mispredict = 1.
- Table update: visible to pred_taken from the cycle after the res_valid edge.
- Reset:
  - Reset is synchronous. While reset = 1, all table entries are written to 01 (weak-NT) on each edge, and training is blocked.
  - Combinational outputs still follow their inputs during reset. After the first reset edge, pred_taken = 0 for every PC.
  - Reset mid-operation discards all training; a pending res_valid in that cycle is ignored.
- Reset values: pred_taken 0 after reset with any PC; mispredict, flush and redirect_taken are 0 whenever res_valid = 0.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on each edge with res_valid; stat_mispredicts increments on each edge with mispredict.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and hold during reset.
- BRANCH_STATS_EN undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - localparams CNT_SNT/CNT_WNT/CNT_WT/CNT_ST
  - the typedef for the 2-bit counter
  - function cnt_next(cnt, taken)
- Sub-module bht_table: the counter array with one combinational read port, one synchronous write port and synchronous reset fill. It is instantiated only when PREDICT_MODE = 1.
- The top level holds index extraction, mispredict/flush logic and the optional stats counters.

## Test plan
- Reset:
  - Stimulus: reset 1 for 2 cycles, then if_valid = 1 with if_pc in {0x0, 0x4, 0x3C}.
  - Response: pred_taken = 0 for each PC; flush = 3'b000.
- Training:
  - Stimulus: res_valid = 1, res_pc = 0x40, res_taken = 1 on two consecutive edges.
  - Response: pred_taken for if_pc = 0x40 becomes 1 from the cycle after the first edge. Two not-taken resolutions then leave it at 0; counter path 01→10→11→10→01.
- Mispredict:
  - Stimulus: res_valid = 1, res_taken = 1, res_pred_taken = 0.
  - Response: mispredict = 1, flush = 3'b111, redirect_taken = 1 in the same cycle. The reversed case gives flush = 3'b111 and redirect_taken = 0. Correct predictions give flush = 0.
- Aliasing and simultaneity:
  - Stimulus (BHT_DEPTH = 16): train PC 0x04 taken twice; read if_pc = 0x44.
  - Response: pred_taken = 1 (shared entry). A same-cycle update and read of an entry return the old value.
- Static mode:
  - Stimulus: PREDICT_MODE = 0, NUM_FLUSH = 4, random res_*.
  - Response: pred_taken is always 0; flush = {4{res_valid & res_taken}} when res_pred_taken = 0.
- Stats (BRANCH_STATS_EN):
  - Stimulus: 10 resolutions, 3 of them mispredicted.
  - Response: stat_branches = 10, stat_mispredicts = 3. Reset returns both to 0. Preloading a counter to max confirms saturation.
